// File: rtl/cond_unit.sv
// cond_unit: holds the architectural NZCV flags, evaluates the ARM condition
// field of the instruction in execute against them, and registers the
// condition-gated write enables into the writeback pipeline slot.
// A flag update becomes visible to the very next instruction's condition check,
// so a compare followed directly by a conditional op needs no bubble.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] cond,
  input  logic [1:0] flag_w,
  input  logic [3:0] alu_nzcv,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  input  logic       stall,
  input  logic       flush,
  output logic       cond_ex,
  output logic [3:0] flags,
  output logic       wb_valid,
  output logic       wb_pcs,
  output logic       wb_reg_w,
  output logic       wb_mem_w
);

  // Full 16-way ARM condition decode against an {N,Z,C,V} value.
  // Code 4'b1111 is the "never" encoding and falls through to the default.
  function automatic logic cond_decode(input logic [3:0] code, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (code)
      4'b0000: pass = z;                       // EQ
      4'b0001: pass = ~z;                      // NE
      4'b0010: pass = c;                       // CS
      4'b0011: pass = ~c;                      // CC
      4'b0100: pass = n;                       // MI
      4'b0101: pass = ~n;                      // PL
      4'b0110: pass = v;                       // VS
      4'b0111: pass = ~v;                      // VC
      4'b1000: pass = c & ~z;                  // HI
      4'b1001: pass = ~c | z;                  // LS
      4'b1010: pass = (n == v);                // GE
      4'b1011: pass = (n != v);                // LT
      4'b1100: pass = ~z & (n == v);           // GT
      4'b1101: pass = z | (n != v);            // LE
      4'b1110: pass = 1'b1;                    // AL
      default: pass = 1'b0;                    // never
    endcase
    return pass;
  endfunction

  logic [3:0] flags_r;
  logic [3:0] flags_nxt_s;
  logic       cond_pass_s;
  logic       acc_s;
  logic       wb_load_s;
  logic       wb_valid_r;
  logic       wb_pcs_r;
  logic       wb_reg_w_r;
  logic       wb_mem_w_r;
  logic       wb_valid_nxt_s;
  logic       wb_pcs_nxt_s;
  logic       wb_reg_w_nxt_s;
  logic       wb_mem_w_nxt_s;

  // The condition is judged from the committed flags, never from alu_nzcv.
  assign cond_pass_s = cond_decode(cond, flags_r);
  assign cond_ex     = cond_pass_s;

  // An instruction is accepted only when live, passing, and neither held nor killed.
  assign acc_s     = in_valid & cond_pass_s & ~stall & ~flush;
  // Flush overrides stall so a killed instruction always clears the wb slot.
  assign wb_load_s = flush | ~stall;

  // Masked flag update: N,Z and C,V halves load independently on accept.
  always_comb begin
    flags_nxt_s = flags_r;
    if (acc_s) begin
      if (flag_w[1]) begin
        flags_nxt_s[3:2] = alu_nzcv[3:2];
      end else begin
        flags_nxt_s[3:2] = flags_r[3:2];
      end
      if (flag_w[0]) begin
        flags_nxt_s[1:0] = alu_nzcv[1:0];
      end else begin
        flags_nxt_s[1:0] = flags_r[1:0];
      end
    end else begin
      flags_nxt_s = flags_r;
    end
  end

  // Flags register; reset wins over any accepted update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= RESET_FLAGS;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  // Next writeback slot contents: gated enables when loading, otherwise hold.
  always_comb begin
    wb_valid_nxt_s = wb_valid_r;
    wb_pcs_nxt_s   = wb_pcs_r;
    wb_reg_w_nxt_s = wb_reg_w_r;
    wb_mem_w_nxt_s = wb_mem_w_r;
    if (wb_load_s) begin
      wb_valid_nxt_s = in_valid & ~flush;
      wb_pcs_nxt_s   = acc_s & pcs;
      wb_reg_w_nxt_s = acc_s & reg_w & ~no_write;
      wb_mem_w_nxt_s = acc_s & mem_w;
    end else begin
      wb_valid_nxt_s = wb_valid_r;
      wb_pcs_nxt_s   = wb_pcs_r;
      wb_reg_w_nxt_s = wb_reg_w_r;
      wb_mem_w_nxt_s = wb_mem_w_r;
    end
  end

  // Writeback pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_r <= 1'b0;
      wb_pcs_r   <= 1'b0;
      wb_reg_w_r <= 1'b0;
      wb_mem_w_r <= 1'b0;
    end else begin
      wb_valid_r <= wb_valid_nxt_s;
      wb_pcs_r   <= wb_pcs_nxt_s;
      wb_reg_w_r <= wb_reg_w_nxt_s;
      wb_mem_w_r <= wb_mem_w_nxt_s;
    end
  end

  assign flags    = flags_r;
  assign wb_valid = wb_valid_r;
  assign wb_pcs   = wb_pcs_r;
  assign wb_reg_w = wb_reg_w_r;
  assign wb_mem_w = wb_mem_w_r;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and random stimulus against a behavioural model;
// expected post-edge state is queued and compared by a separate monitor.
module tb_cond_unit;

  localparam logic [3:0] RST_F = 4'b0000;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic [3:0] alu_nzcv;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       stall;
  logic       flush;
  logic       cond_ex;
  logic [3:0] flags;
  logic       wb_valid;
  logic       wb_pcs;
  logic       wb_reg_w;
  logic       wb_mem_w;

  int checks = 0;
  int fails  = 0;
  bit done   = 1'b0;

  // expected {wb_valid, wb_pcs, wb_reg_w, wb_mem_w, flags[3:0]} after each edge
  logic [7:0] exp_q[$];

  // model state
  logic [3:0] m_flags;
  logic       m_known = 1'b0;
  logic [3:0] m_wb = 4'b0000;

  cond_unit #(.RESET_FLAGS(RST_F)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .cond(cond), .flag_w(flag_w),
    .alu_nzcv(alu_nzcv), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .stall(stall), .flush(flush), .cond_ex(cond_ex), .flags(flags), .wb_valid(wb_valid),
    .wb_pcs(wb_pcs), .wb_reg_w(wb_reg_w), .wb_mem_w(wb_mem_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM-style reference: even codes name a base test, odd codes invert it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    int n = f[3], z = f[2], cy = f[1], v = f[0];
    int base;
    if (c == 4'd15) return 1'b0;
    if (c == 4'd14) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = (cy == 1 && z == 0) ? 1 : 0;
      3'd5: base = (n == v) ? 1 : 0;
      default: base = (z == 0 && n == v) ? 1 : 0;
    endcase
    if (c[0]) base = 1 - base;
    return (base != 0);
  endfunction

  // Drive one cycle, check cond_ex, predict post-edge state, wait for the next negedge.
  task automatic step(input logic rs, input logic iv, input logic [3:0] cd, input logic [1:0] fw,
                      input logic [3:0] nz, input logic p, input logic r, input logic m,
                      input logic nw, input logic st, input logic fl);
    logic pass, acc;
    reset = rs; in_valid = iv; cond = cd; flag_w = fw; alu_nzcv = nz;
    pcs = p; reg_w = r; mem_w = m; no_write = nw; stall = st; flush = fl;
    #1;
    pass = m_known ? ref_cond(cd, m_flags) : 1'b0;
    if (m_known) begin
      checks++;
      if (cond_ex !== pass) begin
        fails++;
        $display("FAIL cond_ex cond=%b flags=%b got=%b want=%b", cd, m_flags, cond_ex, pass);
      end
    end
    if (rs) begin
      m_flags = RST_F;
      m_known = 1'b1;
      m_wb    = 4'b0000;
    end else begin
      acc = iv && pass && !st && !fl;
      if (fl || !st)
        m_wb = {iv && !fl, acc && p, acc && r && !nw, acc && m};
      if (acc) begin
        if (fw[1]) m_flags[3:2] = nz[3:2];
        if (fw[0]) m_flags[1:0] = nz[1:0];
      end
    end
    exp_q.push_back({m_wb, m_flags});
    @(negedge clk);
  endtask

  // Monitor: after every rising edge compare the DUT against the oldest prediction.
  initial begin
    logic [7:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        checks++;
        a = {wb_valid, wb_pcs, wb_reg_w, wb_mem_w, flags};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_empty got=%b want=<queued entry>", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL wb_state t=%0t got v%b p%b r%b m%b f%b want v%b p%b r%b m%b f%b",
                     $time, a[7], a[6], a[5], a[4], a[3:0], e[7], e[6], e[5], e[4], e[3:0]);
          end
        end
      end
    end
  end

  initial begin
    // reset and mask check: EQ with Z=0 must fail, slot valid, no flag change
    step(1,0,4'd0,2'b00,4'd0,0,0,0,0,0,0);
    step(1,0,4'd0,2'b00,4'd0,0,0,0,0,0,0);
    step(0,1,4'd0,2'b11,4'b0100,0,1,0,0,0,0);
    // CMP (AL, no_write) then BEQ back-to-back
    step(0,1,4'd14,2'b11,4'b0110,0,1,0,1,0,0);
    step(0,1,4'd0,2'b00,4'b0000,0,1,0,0,0,0);
    step(0,0,4'd14,2'b00,4'b0000,0,0,0,0,0,0);
    // partial update from flags 1011
    step(0,1,4'd14,2'b11,4'b1011,0,0,0,0,0,0);
    step(0,1,4'd14,2'b10,4'b0100,0,0,0,0,0,0);
    step(0,0,4'd14,2'b00,4'b0000,0,0,0,0,0,0);
    // condition sweep over all flag values
    for (int f = 0; f < 16; f++) begin
      step(0,1,4'd14,2'b11,4'(f),0,0,0,0,0,0);
      for (int c = 0; c < 16; c++)
        step(0,0,4'(c),2'b00,4'($urandom_range(15)),0,0,0,0,0,0);
    end
    // stall then flush-during-stall
    step(0,1,4'd14,2'b11,4'b0011,1,1,1,0,0,0);
    for (int i = 0; i < 3; i++)
      step(0,1,4'd14,2'b11,4'b1000,0,0,1,0,1,0);
    step(0,1,4'd14,2'b11,4'b1000,0,0,1,0,1,1);
    step(0,0,4'd14,2'b00,4'b0000,0,0,0,0,0,0);
    // reset mid-stream with an otherwise accepted update
    step(0,1,4'd14,2'b11,4'b0101,1,1,1,0,0,0);
    step(1,1,4'd14,2'b11,4'b1111,1,1,1,0,0,0);
    step(0,0,4'd14,2'b00,4'b0000,0,0,0,0,0,0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) < 2), $urandom_range(1), 4'($urandom_range(15)),
           2'($urandom_range(3)), 4'($urandom_range(15)), $urandom_range(1),
           $urandom_range(1), $urandom_range(1), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(9) == 0));
    end
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got=%0d left want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-check and flag-holding stage that consumes the ALU's NZCV output. It holds the architectural NZCV flags register and evaluates each instruction's 4-bit ARM condition field against the current flags. It gates the instruction's register-write, memory-write and PC-write enables. It registers the gated enables into the writeback pipeline register, with stall and flush control.

## Interface
- RESET_FLAGS, 4'b0000, NZCV value loaded into the flags register on reset.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an instruction is present in execute this cycle.
- cond  input  4  instruction condition field (ARM encoding).
- flag_w  input  2  flag update mask: bit1 updates N,Z; bit0 updates C,V.
- alu_nzcv  input  4  NZCV produced by the ALU for this instruction ({N,Z,C,V}).
- pcs  input  1  instruction writes PC.
- reg_w  input  1  instruction writes register file.
- mem_w  input  1  instruction writes memory.
- no_write  input  1  compare-type op (CMP/CMN/TST/TEQ): suppress reg_w regardless of condition.
- stall  input  1  hold stage; no state changes.
- flush  input  1  kill the instruction currently in execute.
- cond_ex  output  1  combinational: condition passes for the current instruction.
- flags  output  4  current flags register {N,Z,C,V}.
- wb_valid  output  1  registered: writeback slot holds a live instruction.
- wb_pcs  output  1  registered gated PC write.
- wb_reg_w  output  1  registered gated register write.
- wb_mem_w  output  1  registered gated memory write.

## Operation
- Condition decode (from flags register, not alu_nzcv):
  - EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1.
  - 1111: 0 (never executes).
- cond_ex = decoded condition; it is independent of in_valid.
- Accept condition: acc = in_valid & cond_ex & !stall & !flush.
- Flags update on acc only:
  - flag_w[1] loads N,Z from alu_nzcv[3:2].
  - flag_w[0] loads C,V from alu_nzcv[1:0].
  - Bits whose mask bit is 0 keep their value.
- Writeback register when !stall, or when flush is asserted:
  - wb_valid <= in_valid & !flush.
  - wb_pcs <= acc & pcs.
  - wb_reg_w <= acc & reg_w & !no_write.
  - wb_mem_w <= acc & mem_w.
- Failed-condition instruction: still advances with wb_valid=1, but all enables are 0 and flags are unchanged.
- Priority: reset > flush > stall.
  - flush during stall still clears the wb slot: wb_valid and all enables go to 0, and flags hold.
- Reset values:
  - flags = RESET_FLAGS.
  - wb_valid = wb_pcs = wb_reg_w = wb_mem_w = 0.
- Reset mid-operation discards any instruction in execute and the wb slot; no flag update occurs on the reset edge.

## Timing
- cond_ex: same cycle as the inputs (combinational from the flags register and cond).
- Flag update is visible on flags, and to the next instruction's condition check, one cycle after the accepting edge.
  - A back-to-back CMP then BEQ therefore sees the CMP result with no bubble.
- wb_* outputs: latency 1 from in_valid / enables.
- stall=1: flags and all wb_* hold their values for every stalled cycle; no partial update.
- alu_nzcv is sampled only at the accepting edge; its value is don't-care otherwise.

## Test plan
- Reset and mask check:
  - Stimulus: reset 2 cycles with RESET_FLAGS=4'b0000, then cond=0000 (EQ), in_valid=1, reg_w=1, flag_w=2'b11, alu_nzcv=4'b0100.
  - Required: cond_ex=0, so wb_reg_w=0 and wb_valid=1 next cycle, and flags remain 0000.
- CMP then conditional:
  - Stimulus: cycle 0 AL, no_write=1, flag_w=11, alu_nzcv=0110. Cycle 1 cond=0000, reg_w=1.
  - Required: flags=0110 in cycle 1; cond_ex=1; wb_reg_w=1 in cycle 2; wb_reg_w=0 in cycle 1 (CMP suppressed).
- Partial update:
  - Stimulus: flags=1011, AL, flag_w=2'b10, alu_nzcv=0100.
  - Required: flags=0111 next cycle (C,V preserved).
- Signed conditions:
  - Stimulus: sweep all 16 cond codes against all 16 flag values.
  - Required: cond_ex matches the decode list, e.g. flags 1001 gives GE=1 and LT=0; flags 1000 gives GE=0 and LE=1; 1111 is always 0.
- Stall and flush:
  - Stimulus: AL, mem_w=1, flag_w=11, alu_nzcv=1000 with stall=1 for 3 cycles, then flush=1 with stall=1.
  - Required: flags and wb_* hold through the stall; after the flush edge wb_valid=0, wb_mem_w=0, and flags unchanged.
- Reset mid-stream:
  - Stimulus: reset asserted in the same cycle as an accepted AL, flag_w=11, alu_nzcv=1111.
  - Required: next cycle flags=RESET_FLAGS and all wb_*=0.
